// File: rtl/prog_loader_pkg.sv
// Shared types and default widths for the program loader.
// PROG_LOADER_CHECKSUM_EN adds the CHECK and ERR states.
package prog_loader_pkg;

  localparam int DEF_D = 10;
  localparam int DEF_W = 9;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ERR,
    S_RUN
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_e;
`endif

endpackage

// File: rtl/prog_loader_if.sv
// Source stream, instruction-memory write port and core control.
// The master drives start/len/stream; the slave is the loader.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int D = DEF_D,
  parameter int W = DEF_W
);

  logic         start;
  logic [D:0]   len_in;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_ready;
  logic         im_wr_en;
  logic [D-1:0] im_addr;
  logic [W-1:0] im_wr_data;
  logic         cpu_hold;
  logic         load_done;
  logic         cs_err;

  modport master (
    output start, len_in, s_valid, s_data,
    input  s_ready, im_wr_en, im_addr, im_wr_data,
    input  cpu_hold, load_done, cs_err
  );

  modport slave (
    input  start, len_in, s_valid, s_data,
    output s_ready, im_wr_en, im_addr, im_wr_data,
    output cpu_hold, load_done, cs_err
  );

endinterface

// File: rtl/prog_loader_ld_checksum.sv
// Running XOR of loaded words, compared against the check word.
// Only built when PROG_LOADER_CHECKSUM_EN is defined.
`ifdef PROG_LOADER_CHECKSUM_EN
module ld_checksum #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic         match_o
);

  logic [W-1:0] acc_q, acc_d;

  // Clear on a new load, fold in every loaded word
  always_comb begin
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (en_i)
      acc_d = acc_q ^ data_i;
  end

  // Accumulator register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

  assign match_o = (acc_q == data_i);

endmodule
`endif

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, then releases the core.
// PROG_LOADER_CHECKSUM_EN enables a trailing XOR check word.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int D = DEF_D,
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           reset,
  prog_loader_if.slave   bus
);

  localparam logic [D:0] MAX_LEN = {1'b1, {D{1'b0}}};
  localparam logic [D:0] ONE     = {{D{1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [D:0]   len_q, len_d;
  logic [D:0]   cnt_q, cnt_d;
  logic         wr_en_q, wr_en_d;
  logic [D-1:0] addr_q, addr_d;
  logic [W-1:0] data_q, data_d;

  logic s_ready;
  logic xfer;
  logic len_ok;
  logic can_start;
  logic accept;
  logic last;
  logic load_xfer;
  logic ck_match;

  assign xfer      = bus.s_valid && s_ready;
  assign len_ok    = (bus.len_in != '0) && (bus.len_in <= MAX_LEN);
  assign accept    = bus.start && len_ok && can_start;
  assign last      = (cnt_q == (len_q - ONE));
  assign load_xfer = xfer && (state_q == S_LOAD);

`ifdef PROG_LOADER_CHECKSUM_EN
  ld_checksum #(
    .W (W)
  ) u_ck (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (accept),
    .en_i    (load_xfer),
    .data_i  (bus.s_data),
    .match_o (ck_match)
  );
`else
  assign ck_match = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept)
          state_d = S_LOAD;
      end
      S_LOAD: begin
        if (xfer && last)
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_RUN;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer)
          state_d = ck_match ? S_RUN : S_ERR;
      end
      S_ERR: begin
        if (accept)
          state_d = S_LOAD;
      end
`endif
      S_RUN: begin
        if (accept)
          state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    s_ready       = 1'b0;
    can_start     = 1'b0;
    bus.cpu_hold  = 1'b1;
    bus.load_done = 1'b0;
    bus.cs_err    = 1'b0;
    unique case (state_q)
      S_IDLE: can_start = 1'b1;
      S_LOAD: s_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: s_ready = 1'b1;
      S_ERR: begin
        can_start  = 1'b1;
        bus.cs_err = 1'b1;
      end
`endif
      S_RUN: begin
        can_start     = 1'b1;
        bus.cpu_hold  = 1'b0;
        bus.load_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.s_ready = s_ready;

  // Length latch, word counter and write-port staging
  always_comb begin
    len_d   = len_q;
    cnt_d   = cnt_q;
    wr_en_d = load_xfer;
    addr_d  = addr_q;
    data_d  = data_q;
    if (accept) begin
      len_d = bus.len_in;
      cnt_d = '0;
    end else if (load_xfer) begin
      cnt_d = cnt_q + ONE;
    end
    if (load_xfer) begin
      addr_d = cnt_q[D-1:0];
      data_d = bus.s_data;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q   <= '0;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.im_wr_en   = wr_en_q;
  assign bus.im_addr    = addr_q;
  assign bus.im_wr_data = data_q;

  // Unused when the checksum is compiled out
  logic unused_ok;
  assign unused_ok = ck_match;

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized loads against a queue-based write model.
// Define PROG_LOADER_CHECKSUM_EN to exercise the check-word path.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int D = DEF_D;
  localparam int W = DEF_W;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;

  wr_t          exp_q[$];
  wr_t          obs_q[$];
  logic [W-1:0] wq[$];

  prog_loader_if #(.D(D), .W(W)) bus ();

  prog_loader #(.D(D), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.im_wr_en === 1'b1)
      obs_q.push_back('{cyc, int'(bus.im_addr), int'(bus.im_wr_data)});

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.s_ready), 0);
    chk({tag, "_wren"}, 32'(bus.im_wr_en), 0);
    chk({tag, "_addr"}, 32'(bus.im_addr), 0);
    chk({tag, "_wdata"}, 32'(bus.im_wr_data), 0);
    chk({tag, "_hold"}, 32'(bus.cpu_hold), 1);
    chk({tag, "_done"}, 32'(bus.load_done), 0);
    chk({tag, "_cserr"}, 32'(bus.cs_err), 0);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    chk({tag, "_wcount"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_waddr"}, 32'(obs_q[i].addr), 32'(exp_q[i].addr));
      chk({tag, "_wdata"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
      chk({tag, "_wcyc"}, 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic fill_rand(input int n);
    wq.delete();
    for (int i = 0; i < n; i++)
      wq.push_back(W'($urandom));
  endtask

  task automatic pulse_start(input int len);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.len_in = (D + 1)'(len);
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  // Loads wq; stalls sit before word stall_at, plus optional random ones
  task automatic do_load(input string tag, input int stall_at,
                         input int stall_n, input bit rnd,
                         input bit poke, input bit ck_good);
    int           k;
    logic [W-1:0] x;
    bit           ok;
    x = '0;
    pulse_start(wq.size());
    chk({tag, "_hold_on_start"}, 32'(bus.cpu_hold), 1);
    chk({tag, "_done_on_start"}, 32'(bus.load_done), 0);
    chk({tag, "_cserr_on_start"}, 32'(bus.cs_err), 0);
    for (int i = 0; i < wq.size(); i++) begin
      k = (i == stall_at) ? stall_n : 0;
      if (rnd && $urandom_range(0, 3) == 0)
        k += $urandom_range(1, 3);
      for (int s = 0; s < k; s++) begin
        bus.s_valid = 1'b0;
        bus.s_data  = W'($urandom);
        bus.start   = poke;
        bus.len_in  = (D + 1)'($urandom_range(0, 8));
        chk({tag, "_ready_stall"}, 32'(bus.s_ready), 1);
        chk({tag, "_hold_stall"}, 32'(bus.cpu_hold), 1);
        @(negedge clk);
        bus.start = 1'b0;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = wq[i];
      chk({tag, "_ready_word"}, 32'(bus.s_ready), 1);
      exp_q.push_back('{cyc + 1, i, int'(wq[i])});
      x ^= wq[i];
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    ok = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
    chk({tag, "_hold_check"}, 32'(bus.cpu_hold), 1);
    bus.s_valid = 1'b1;
    bus.s_data  = ck_good ? x : (x ^ W'(1));
    chk({tag, "_ready_check"}, 32'(bus.s_ready), 1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    ok = ck_good;
`else
    if (!ck_good) ok = 1'b1;
`endif
    chk({tag, "_done"}, 32'(bus.load_done), 32'(ok));
    chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'(!ok));
`ifdef PROG_LOADER_CHECKSUM_EN
    chk({tag, "_cserr"}, 32'(bus.cs_err), 32'(!ok));
`else
    chk({tag, "_cserr"}, 32'(bus.cs_err), 0);
`endif
    chk({tag, "_ready_after"}, 32'(bus.s_ready), 0);
    repeat (2) @(negedge clk);
    compare_writes(tag);
  endtask

  initial begin
    #3_000_000;
    errs++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.len_in  = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    #3;
    chk_reset_vals("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // zero length is ignored in IDLE
    pulse_start(0);
    @(negedge clk);
    chk("len0_idle_ready", 32'(bus.s_ready), 0);
    chk("len0_idle_hold", 32'(bus.cpu_hold), 1);

    // three back-to-back words
    wq.delete();
    wq.push_back(9'h1A5);
    wq.push_back(9'h003);
    wq.push_back(9'h0FF);
    do_load("b2b", -1, 0, 1'b0, 1'b0, 1'b1);

    // zero length is ignored in RUN
    pulse_start(0);
    @(negedge clk);
    chk("len0_run_done", 32'(bus.load_done), 1);
    chk("len0_run_hold", 32'(bus.cpu_hold), 0);

    // five-cycle source stall between words 1 and 2
    fill_rand(4);
    do_load("stall", 2, 5, 1'b0, 1'b0, 1'b1);

    // randomized loads with starts poked mid-load
    for (int r = 0; r < 6; r++) begin
      fill_rand($urandom_range(1, 40));
      do_load("rand", -1, 0, 1'b1, 1'b1, 1'b1);
    end

    // full-depth load
    fill_rand(1 << D);
    exp_q.delete();
    do_load("full", -1, 0, 1'b0, 1'b0, 1'b1);
    chk("full_last_addr", 32'(bus.im_addr), 32'h3FF);

    // reset after 2 of 5 words, pending write suppressed
    fill_rand(5);
    pulse_start(5);
    bus.s_valid = 1'b1;
    bus.s_data  = wq[0];
    exp_q.push_back('{cyc + 1, 0, int'(wq[0])});
    @(negedge clk);
    bus.s_data = wq[1];
    @(posedge clk);
    #1;
    reset       = 1'b1;
    bus.s_valid = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compare_writes("midrst");
    do_load("after_rst", -1, 0, 1'b0, 1'b0, 1'b1);

`ifdef PROG_LOADER_CHECKSUM_EN
    // matching and mismatching check words
    wq.delete();
    wq.push_back(9'h001);
    wq.push_back(9'h002);
    do_load("ck_ok", -1, 0, 1'b0, 1'b0, 1'b1);
    do_load("ck_bad", -1, 0, 1'b0, 1'b0, 1'b0);
    fill_rand(3);
    do_load("ck_recover", -1, 0, 1'b1, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
